// File: rtl/axis_fifo_slice.sv
// AXI-stream FIFO slice: DEPTH entries at one beat per cycle. Every output, including
// the head data, tlast, level and flags, is driven straight from a flop.
module axis_fifo_slice #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W:0] mem_q [DEPTH];
  logic [DATA_W:0] wdata;
  logic [DATA_W:0] head_d, head_q;

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [LVL_W-1:0] level_d, level_q;
  logic             s_ready_d, s_ready_q;
  logic             m_valid_d, m_valid_q;
  logic             afull_d, afull_q;
  logic             push, pop;

  always_comb begin
    wdata     = {s_axis_tlast, s_axis_tdata};
    push      = s_axis_tvalid & s_ready_q;
    pop       = m_valid_q & m_axis_tready;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
    s_ready_d = (level_d != LVL_W'(DEPTH));
    m_valid_d = (level_d != '0);
    afull_d   = (level_d >= LVL_W'(AFULL_TH));
    // A push into the slot that becomes the head (FIFO draining to empty) must bypass
    // the array, since the write lands on the same edge as the head register update.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      afull_q   <= afull_d;
    end
  end

  // Storage and head register carry no reset; they are ignored while m_axis_tvalid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
    head_q <= head_d;
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = head_q[DATA_W-1:0];
  assign m_axis_tlast  = head_q[DATA_W];
  assign level         = level_q;
  assign almost_full   = afull_q;

endmodule

// File: tb/tb_axis_fifo_slice.sv
// Self-checking bench for axis_fifo_slice: a queue model of the FIFO is advanced every
// clock and the DUT outputs are compared against it on the falling edge.
module tb_axis_fifo_slice;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic [2:0]        level;
  logic              almost_full;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [DATA_W:0] exp_q[$];

  always #5 clk = ~clk;

  axis_fifo_slice #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .level(level), .almost_full(almost_full)
  );

  // Expected {level, s_tready, m_tvalid, almost_full} from the number of held beats.
  function automatic logic [5:0] exp_flags();
    int n = exp_q.size();
    return {3'(n), n != DEPTH, n != 0, n >= AFULL_TH};
  endfunction

  // Model step: a beat is accepted when fewer than DEPTH are held, a beat leaves when any is held.
  task automatic tick();
    bit push, pop;
    @(posedge clk);
    push = s_tvalid && (exp_q.size() != DEPTH);
    pop  = m_tready && (exp_q.size() != 0);
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (push) begin
        exp_q.push_back({s_tlast, s_tdata});
        n_push++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if ({level, s_tready, m_tvalid, almost_full} !== 6'b000_1_0_0) begin
      errors++;
      $display("FAIL reset_flags cyc=%0d got=%b want=%b", cyc,
               {level, s_tready, m_tvalid, almost_full}, 6'b000_1_0_0);
    end
    $display("reset: level=%0d tready=%b tvalid=%b afull=%b", level, s_tready, m_tvalid, almost_full);
  endtask

  task automatic test_stream();
    int nxt = 1;
    m_tready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      s_tvalid = (i <= 16);
      s_tdata  = DATA_W'(i);
      s_tlast  = (i == 16);
      checks++;
      if ({level, s_tready, m_tvalid, almost_full} !== exp_flags() || level > 3'd1) begin
        errors++;
        $display("FAIL stream_flags cyc=%0d got=%b want=%b", cyc,
                 {level, s_tready, m_tvalid, almost_full}, exp_flags());
      end
      if (i >= 2 && i <= 17) begin
        checks++;
        if (!m_tvalid || m_tdata !== DATA_W'(nxt)) begin
          errors++;
          $display("FAIL stream_order cyc=%0d got valid=%b data=%0d want data=%0d", cyc, m_tvalid, m_tdata, nxt);
        end
        nxt++;
      end
      $display("stream: in=%0d out_valid=%b out=%0d level=%0d", i, m_tvalid, m_tdata, level);
      tick();
    end
  endtask

  task automatic test_fill();
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DATA_W'(32'h100 + ((i < 4) ? i : 4));
      s_tlast  = 1'b0;
      checks++;
      if ({level, s_tready, m_tvalid, almost_full} !== exp_flags()) begin
        errors++;
        $display("FAIL fill_flags cyc=%0d got=%b want=%b", cyc,
                 {level, s_tready, m_tvalid, almost_full}, exp_flags());
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({m_tlast, m_tdata} !== exp_q[0]) begin
          errors++;
          $display("FAIL fill_head cyc=%0d got=%h want=%h", cyc, {m_tlast, m_tdata}, exp_q[0]);
        end
      end
      $display("fill: in=%h level=%0d tready=%b afull=%b", s_tdata, level, s_tready, almost_full);
      tick();
    end
    checks++;
    if ({level, s_tready, almost_full} !== 5'b100_0_1) begin
      errors++;
      $display("FAIL fill_full cyc=%0d got=%b want=%b", cyc, {level, s_tready, almost_full}, 5'b100_0_1);
    end
  endtask

  task automatic test_full_stream();
    int in_k = 4;
    int out_k = 0;
    bit acc;
    m_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DATA_W'(32'h100 + in_k);
      s_tlast  = 1'b0;
      checks++;
      if ({level, s_tready, m_tvalid, almost_full} !== exp_flags()) begin
        errors++;
        $display("FAIL fullstr_flags cyc=%0d got=%b want=%b", cyc,
                 {level, s_tready, m_tvalid, almost_full}, exp_flags());
      end
      checks++;
      if (!m_tvalid || m_tdata !== DATA_W'(32'h100 + out_k)) begin
        errors++;
        $display("FAIL fullstr_order cyc=%0d got=%h want=%h", cyc, m_tdata, 32'h100 + out_k);
      end
      $display("fullstr: in=%h out=%h level=%0d", s_tdata, m_tdata, level);
      out_k++;
      acc = (exp_q.size() != DEPTH);
      tick();
      if (acc) in_k++;
    end
    drain();
  endtask

  task automatic test_random();
    int beat = 0;
    int npush0 = n_push;
    int npop0 = n_pop;
    for (int c = 0; c < 60000 && (n_push - npush0) < 10000; c++) begin
      beat     = n_push - npush0;
      s_tvalid = $urandom_range(0, 1);
      m_tready = $urandom_range(0, 1);
      s_tdata  = $urandom;
      s_tlast  = (beat % 7 == 6);
      checks++;
      if ({level, s_tready, m_tvalid, almost_full} !== exp_flags() ||
          int'(level) != (n_push - npush0) - (n_pop - npop0)) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d got=%b want=%b", cyc,
                 {level, s_tready, m_tvalid, almost_full}, exp_flags());
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({m_tlast, m_tdata} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_head cyc=%0d got=%h want=%h", cyc, {m_tlast, m_tdata}, exp_q[0]);
        end
      end
      tick();
    end
    checks++;
    if (n_push - npush0 < 10000) begin
      errors++;
      $display("FAIL rand_budget pushes got=%0d want=10000", n_push - npush0);
    end
    $display("random: pushes=%0d pops=%0d", n_push - npush0, n_pop - npop0);
    drain();
  endtask

  task automatic test_wrap();
    int in_k = 0;
    int out_k = 0;
    bit acc;
    for (int c = 0; c < 100 && out_k < 3*DEPTH+1; c++) begin
      s_tvalid = (in_k < 3*DEPTH+1);
      s_tdata  = DATA_W'(32'h200 + in_k);
      s_tlast  = (in_k == 3*DEPTH);
      m_tready = c[0];
      checks++;
      if ({level, s_tready, m_tvalid, almost_full} !== exp_flags()) begin
        errors++;
        $display("FAIL wrap_flags cyc=%0d got=%b want=%b", cyc,
                 {level, s_tready, m_tvalid, almost_full}, exp_flags());
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (m_tdata !== DATA_W'(32'h200 + out_k) || m_tlast !== (out_k == 3*DEPTH)) begin
          errors++;
          $display("FAIL wrap_order cyc=%0d got=%h want=%h", cyc, m_tdata, 32'h200 + out_k);
        end
        $display("wrap: out=%h last=%b", m_tdata, m_tlast);
        out_k++;
      end
      acc = s_tvalid && (exp_q.size() != DEPTH);
      tick();
      if (acc) in_k++;
    end
    checks++;
    if (out_k != 3*DEPTH+1) begin
      errors++;
      $display("FAIL wrap_count got=%0d want=%0d", out_k, 3*DEPTH+1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DATA_W'(32'h300 + i);
      tick();
    end
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_pre cyc=%0d got=%0d want=3", cyc, level);
    end
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({level, s_tready, m_tvalid, almost_full} !== 6'b000_1_0_0) begin
      errors++;
      $display("FAIL rstmid_flags cyc=%0d got=%b want=%b", cyc,
               {level, s_tready, m_tvalid, almost_full}, 6'b000_1_0_0);
    end
    s_tvalid = 1'b1;
    s_tdata  = 32'hCAFE_0001;
    s_tlast  = 1'b1;
    tick();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    checks++;
    if (!m_tvalid || m_tdata !== 32'hCAFE_0001 || m_tlast !== 1'b1 || level !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_first cyc=%0d got valid=%b data=%h level=%0d want data=cafe0001 level=1",
               cyc, m_tvalid, m_tdata, level);
    end
    $display("reset_mid: first_out=%h level=%0d", m_tdata, level);
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_full_stream();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
